// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared constants, stage state type and select-width helper for rr_mux_arbiter
package rr_mux_pkg;
   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_RR     = 1'b1;
   typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;
   function automatic int sel_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/rr_mux_arbiter_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority search starting just above ptr
module rr_arbiter
   import rr_mux_pkg::*;
#(
   parameter  int NCH  = 4,
   localparam int SELW = sel_width(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic            gnt_valid,
   output logic [SELW-1:0] gnt_idx
);
   logic [SELW-1:0] idx;
   // scan farthest-first so the closest requester after ptr wins
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = '0;
      for (int k = NCH; k >= 1; k--) begin
         idx = SELW'((int'(ptr) + k) % NCH);
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = idx;
         end
      end
   end
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: manual/round-robin N-channel mux into one registered valid/ready stage
module rr_mux_arbiter
   import rr_mux_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int NCH   = 4,
   localparam int SELW  = sel_width(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_chan,
   output logic                 out_valid,
   input  logic                 out_ready
);
   state_t            state_q, state_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [SELW-1:0]   chan_q, chan_d;
   logic [SELW-1:0]   ptr_q, ptr_d;
   logic              rr_valid, man_valid, gnt_valid, load_en, xfer;
   logic [SELW-1:0]   rr_idx, gnt_idx;

   rr_arbiter #(.NCH(NCH)) u_arb (
      .req       (in_valid),
      .ptr       (ptr_q),
      .gnt_valid (rr_valid),
      .gnt_idx   (rr_idx)
   );

   always_comb begin
      man_valid = (int'(sel) < NCH) && in_valid[sel];
      gnt_valid = (mode == MODE_RR) ? rr_valid : man_valid;
      gnt_idx   = (mode == MODE_RR) ? rr_idx : sel;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = xfer ? ST_FULL : (out_ready ? ST_EMPTY : state_q);
   end

   always_comb begin
      load_en  = (state_q == ST_EMPTY) || out_ready;
      xfer     = rst_n && load_en && gnt_valid;
      in_ready = xfer ? (NCH'(1) << gnt_idx) : '0;
   end

   always_comb begin
      data_d = xfer ? in_data[gnt_idx*WIDTH +: WIDTH] : data_q;
      chan_d = xfer ? gnt_idx : chan_q;
      ptr_d  = (xfer && mode == MODE_RR) ? gnt_idx : ptr_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q <= '0;
         chan_q <= '0;
         ptr_q  <= SELW'(NCH - 1);
      end else begin
         data_q <= data_d;
         chan_q <= chan_d;
         ptr_q  <= ptr_d;
      end
   end

   assign out_data  = data_q;
   assign out_chan  = chan_q;
   assign out_valid = (state_q == ST_FULL);
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: scenario tasks with an expected-word scoreboard for rr_mux_arbiter
module tb_rr_mux_arbiter;
   logic        clk = 1'b0;
   logic        rst_n, mode, out_ready, out_valid;
   logic [1:0]  sel, out_chan;
   logic [31:0] in_data;
   logic [3:0]  in_valid, in_ready;
   logic [7:0]  out_data;
   int          tests = 0;
   int          fails = 0;

   typedef struct {logic [1:0] ch; logic [7:0] d;} exp_t;
   exp_t sb[$];
   exp_t e;

   rr_mux_arbiter #(.WIDTH(8), .NCH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 4'h0;
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      mode      = 1'b1;
      sel       = 2'd0;
      in_valid  = 4'hf;
      in_data   = 32'h44332211;
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         tests++;
         if ({out_valid, in_ready, out_data} !== 13'h0) begin
            fails++;
            $display("FAIL reset_state: valid=%b ready=%b data=%h, want 0/0/00", out_valid, in_ready, out_data);
         end
      end
      rst_n = 1'b1;
      #1;
      tests++;
      if (in_ready !== 4'b0001) begin
         fails++;
         $display("FAIL reset_first_ready: got %b want 0001", in_ready);
      end
      @(negedge clk);
      tests++;
      if ({out_valid, out_chan, out_data} !== {1'b1, 2'd0, 8'h11}) begin
         fails++;
         $display("FAIL reset_first_grant: v=%b ch=%0d d=%h want 1/0/11", out_valid, out_chan, out_data);
      end
      in_valid = 4'h0;
   endtask

   task automatic test_round_robin();
      do_reset();
      mode      = 1'b1;
      in_data   = 32'h44332211;
      out_ready = 1'b1;
      in_valid  = 4'hf;
      for (int i = 0; i < 5; i++) sb.push_back('{ch: 2'(i % 4), d: 8'(8'h11 * ((i % 4) + 1))});
      while (sb.size() > 0) begin
         #1;
         tests++;
         if (in_ready !== (4'b1 << sb[0].ch)) begin
            fails++;
            $display("FAIL rr_ready: got %b want %b", in_ready, 4'b1 << sb[0].ch);
         end
         @(negedge clk);
         e = sb.pop_front();
         tests++;
         if ({out_valid, out_chan, out_data} !== {1'b1, e.ch, e.d}) begin
            fails++;
            $display("FAIL rr_out: v=%b ch=%0d d=%h want 1/%0d/%h", out_valid, out_chan, out_data, e.ch, e.d);
         end
      end
      in_valid = 4'h0;
   endtask

   task automatic test_sparse();
      do_reset();
      mode      = 1'b1;
      out_ready = 1'b1;
      in_valid  = 4'b1010;
      for (int i = 0; i < 4; i++) sb.push_back('{ch: (i % 2 == 0) ? 2'd1 : 2'd3, d: (i % 2 == 0) ? 8'h22 : 8'h44});
      while (sb.size() > 0) begin
         #1;
         tests++;
         if (in_ready !== (4'b1 << sb[0].ch)) begin
            fails++;
            $display("FAIL sparse_ready: got %b want %b", in_ready, 4'b1 << sb[0].ch);
         end
         @(negedge clk);
         e = sb.pop_front();
         tests++;
         if ({out_valid, out_chan, out_data} !== {1'b1, e.ch, e.d}) begin
            fails++;
            $display("FAIL sparse_out: v=%b ch=%0d d=%h want 1/%0d/%h", out_valid, out_chan, out_data, e.ch, e.d);
         end
      end
      in_valid = 4'h0;
   endtask

   task automatic test_manual();
      do_reset();
      mode      = 1'b0;
      sel       = 2'd2;
      out_ready = 1'b1;
      in_valid  = 4'hf;
      repeat (3) sb.push_back('{ch: 2'd2, d: 8'h33});
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         tests++;
         if ({out_valid, out_chan, out_data, dut.ptr_q} !== {1'b1, e.ch, e.d, 2'd3}) begin
            fails++;
            $display("FAIL manual_out: v=%b ch=%0d d=%h ptr=%0d want 1/%0d/%h/3", out_valid, out_chan, out_data, dut.ptr_q, e.ch, e.d);
         end
      end
      mode = 1'b1;
      sb.push_back('{ch: 2'd0, d: 8'h11});
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if ({out_valid, out_chan, out_data, dut.ptr_q} !== {1'b1, e.ch, e.d, 2'd0}) begin
         fails++;
         $display("FAIL manual_to_rr: v=%b ch=%0d d=%h ptr=%0d want 1/0/11/0", out_valid, out_chan, out_data, dut.ptr_q);
      end
      in_valid = 4'h0;
   endtask

   task automatic test_backpressure();
      do_reset();
      mode      = 1'b0;
      sel       = 2'd1;
      in_data   = 32'h4433a511;
      in_valid  = 4'b0010;
      out_ready = 1'b0;
      sb.push_back('{ch: 2'd1, d: 8'ha5});
      sb.push_back('{ch: 2'd1, d: 8'h5a});
      @(negedge clk);
      in_data = 32'h44335a11;
      repeat (5) begin
         #1;
         tests++;
         if ({in_ready, out_valid, out_chan, out_data} !== {4'b0, 1'b1, sb[0].ch, sb[0].d}) begin
            fails++;
            $display("FAIL bp_stall: rdy=%b v=%b ch=%0d d=%h want 0000/1/%0d/%h", in_ready, out_valid, out_chan, out_data, sb[0].ch, sb[0].d);
         end
         @(negedge clk);
      end
      void'(sb.pop_front());
      out_ready = 1'b1;
      #1;
      tests++;
      if (in_ready !== 4'b0010) begin
         fails++;
         $display("FAIL bp_release_ready: got %b want 0010", in_ready);
      end
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if ({out_valid, out_chan, out_data} !== {1'b1, e.ch, e.d}) begin
         fails++;
         $display("FAIL bp_reload: v=%b ch=%0d d=%h want 1/%0d/%h", out_valid, out_chan, out_data, e.ch, e.d);
      end
      in_valid = 4'h0;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      mode      = 1'b1;
      in_data   = 32'h44332211;
      in_valid  = 4'hf;
      out_ready = 1'b0;
      @(negedge clk);
      tests++;
      if ({out_valid, out_chan, dut.ptr_q} !== {1'b1, 2'd0, 2'd0}) begin
         fails++;
         $display("FAIL midrst_full: v=%b ch=%0d ptr=%0d want 1/0/0", out_valid, out_chan, dut.ptr_q);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if (in_ready !== 4'b0) begin
         fails++;
         $display("FAIL midrst_ready: got %b want 0000", in_ready);
      end
      @(negedge clk);
      tests++;
      if ({out_valid, dut.ptr_q, out_data} !== {1'b0, 2'd3, 8'h00}) begin
         fails++;
         $display("FAIL midrst_clear: v=%b ptr=%0d d=%h want 0/3/00", out_valid, dut.ptr_q, out_data);
      end
      rst_n    = 1'b1;
      in_valid = 4'h0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_sparse();
      test_manual();
      test_backpressure();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
